// File: rtl/vpin_pkg.sv
// Shared widths, constants and the commit state type for the virtual-pin endpoint.
package vpin_pkg;

  localparam int SW_W       = 10;
  localparam int KEY_W      = 2;
  localparam int PARAM_W    = 32;
  localparam int DIGITS     = 6;
  localparam int STATUS_W   = 9;
  localparam int COMMIT_BIT = 9;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    IDLE,
    PENDING
  } commit_state_t;

endpackage

// File: rtl/hex7seg.sv
// Nibble to display pattern; active-low seven-segment when VPIN_HEX_DECODE_EN is defined,
// otherwise the raw nibble is passed through for the host to decode.
module hex7seg
  import vpin_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

`ifdef VPIN_HEX_DECODE_EN
  // Segments a..g on bits 0..6, decimal point (bit 7) always off.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = SEG_BLANK;
    endcase
  end
`else
  assign seg = {4'b0000, nibble};
`endif

endmodule

// File: rtl/vpin_endpoint.sv
// Design-side endpoint of the JTAG virtual-pin interface: input synchronizers, key pulses,
// toggle-based atomic config commit, status and display registers. Option: VPIN_HEX_DECODE_EN.
module vpin_endpoint
  import vpin_pkg::*;
(
  input  logic                 CYCLONEV_CLK_50,
  input  logic                 reset,
  input  logic [SW_W-1:0]      SW,
  input  logic [KEY_W-1:0]     KEY,
  input  logic [PARAM_W-1:0]   param1,
  input  logic [PARAM_W-1:0]   param2,
  input  logic [PARAM_W-1:0]   param3,
  output logic [SW_W-1:0]      LEDR,
  output logic [7:0]           HEX0,
  output logic [7:0]           HEX1,
  output logic [7:0]           HEX2,
  output logic [7:0]           HEX3,
  output logic [7:0]           HEX4,
  output logic [7:0]           HEX5,
  output logic [SW_W-2:0]      sw_out,
  output logic [KEY_W-1:0]     key_press,
  output logic [PARAM_W-1:0]   cfg_p1,
  output logic [PARAM_W-1:0]   cfg_p2,
  output logic [PARAM_W-1:0]   cfg_p3,
  output logic                 cfg_valid,
  input  logic                 cfg_ready,
  input  logic [STATUS_W-1:0]  status_in,
  input  logic [4*DIGITS-1:0]  disp_value,
  input  logic                 disp_load
);

`ifdef VPIN_HEX_DECODE_EN
  localparam logic [7:0] HEX_RESET = SEG_BLANK;
`else
  localparam logic [7:0] HEX_RESET = 8'h00;
`endif

  logic [SW_W-1:0]     sw_s1_reg, sw_s2_reg, sw_s3_reg;
  logic [KEY_W-1:0]    key_s1_reg, key_s2_reg, key_s3_reg;
  logic [KEY_W-1:0]    key_press_reg;
  logic [STATUS_W-1:0] status_reg;

  // The third SW stage keeps SW and KEY at identical sync depth; nothing reads it.
  logic unused_sw_s3;
  assign unused_sw_s3 = ^sw_s3_reg;

  always_ff @(posedge CYCLONEV_CLK_50) begin
    if (reset) begin
      sw_s1_reg  <= '0;
      sw_s2_reg  <= '0;
      sw_s3_reg  <= '0;
      key_s1_reg <= '0;
      key_s2_reg <= '0;
      key_s3_reg <= '0;
      status_reg <= '0;
    end else begin
      sw_s1_reg  <= SW;
      sw_s2_reg  <= sw_s1_reg;
      sw_s3_reg  <= sw_s2_reg;
      key_s1_reg <= KEY;
      key_s2_reg <= key_s1_reg;
      key_s3_reg <= key_s2_reg;
      status_reg <= status_in;
    end
  end

  for (genvar gi = 0; gi < KEY_W; gi++) begin : g_key
    always_ff @(posedge CYCLONEV_CLK_50) begin
      if (reset) key_press_reg[gi] <= 1'b0;
      else       key_press_reg[gi] <= key_s2_reg[gi] & ~key_s3_reg[gi];
    end
  end

  // Commit handshake. Params are host-static while the toggle propagates, so they are
  // captured without synchronization on the cycle the synchronized toggle is seen.
  commit_state_t      state_reg;
  logic               ack_reg;
  logic               toggle_reg;
  logic               valid_reg;
  logic [PARAM_W-1:0] p1_reg, p2_reg, p3_reg;

  always_ff @(posedge CYCLONEV_CLK_50) begin
    if (reset) begin
      state_reg  <= IDLE;
      ack_reg    <= 1'b0;
      toggle_reg <= 1'b0;
      valid_reg  <= 1'b0;
      p1_reg     <= '0;
      p2_reg     <= '0;
      p3_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sw_s2_reg[COMMIT_BIT] != ack_reg) begin
            p1_reg     <= param1;
            p2_reg     <= param2;
            p3_reg     <= param3;
            toggle_reg <= sw_s2_reg[COMMIT_BIT];
            valid_reg  <= 1'b1;
            state_reg  <= PENDING;
          end
        end
        PENDING: begin
          if (cfg_ready) begin
            valid_reg <= 1'b0;
            ack_reg   <= toggle_reg;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [7:0] seg_next [DIGITS];
  logic [7:0] hex_reg  [DIGITS];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    hex7seg u_hex7seg (
      .nibble (disp_value[4*gi +: 4]),
      .seg    (seg_next[gi])
    );
  end

  always_ff @(posedge CYCLONEV_CLK_50) begin
    for (int i = 0; i < DIGITS; i++) begin
      if (reset)          hex_reg[i] <= HEX_RESET;
      else if (disp_load) hex_reg[i] <= seg_next[i];
    end
  end

  assign sw_out    = sw_s2_reg[SW_W-2:0];
  assign key_press = key_press_reg;
  assign cfg_p1    = p1_reg;
  assign cfg_p2    = p2_reg;
  assign cfg_p3    = p3_reg;
  assign cfg_valid = valid_reg;
  assign LEDR      = {ack_reg, status_reg};
  assign HEX0      = hex_reg[0];
  assign HEX1      = hex_reg[1];
  assign HEX2      = hex_reg[2];
  assign HEX3      = hex_reg[3];
  assign HEX4      = hex_reg[4];
  assign HEX5      = hex_reg[5];

endmodule
